// File: rtl/ex_muldiv_unit_if.sv
// Operand, control and result bundle between the EX stage and the
// iterative multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO.
// Operands are reduced to magnitudes at launch, WIDTH iterations of
// shift-add (multiply) or restoring division run in RUN, and signs are
// reapplied on the FINISH edge when HI/LO are written.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes accepted
// RUN    | one multiplier / quotient bit per edge, WIDTH edges
// FINISH | sign fix-up, HI/LO update, done pulse
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_div_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;

  logic               sa_d;
  logic               sb_d;
  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH+1:0]   div_shift_d;
  logic [WIDTH+1:0]   div_diff_d;
  logic               div_ok_d;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [2*WIDTH-1:0] prod_res_d;
  logic [WIDTH-1:0]   quo_res_d;
  logic [WIDTH-1:0]   rem_res_d;

  // Launch-time sign extraction and magnitudes; 0x80000000 negates to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    sa_d    = ~bus.op[0] & bus.operand_a[WIDTH-1];
    sb_d    = ~bus.op[0] & bus.operand_b[WIDTH-1];
    mag_a_d = sa_d ? -bus.operand_a : bus.operand_a;
    mag_b_d = sb_d ? -bus.operand_b : bus.operand_b;
  end

  // One iteration of each datapath plus the final sign fix-up.
  // The shift/subtract is WIDTH+2 bits so the top bit is a clean borrow.
  always_comb begin
    mul_sum_d   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
    prod_d      = prod_q[0] ? {mul_sum_d, prod_q[WIDTH-1:1]}
                            : {1'b0, prod_q[2*WIDTH-1:1]};
    div_shift_d = {rem_q, quo_q[WIDTH-1]};
    div_diff_d  = div_shift_d - {2'b00, mag_b_q};
    div_ok_d    = ~div_diff_d[WIDTH+1];
    rem_d       = div_ok_d ? div_diff_d[WIDTH:0] : div_shift_d[WIDTH:0];
    quo_d       = {quo_q[WIDTH-2:0], div_ok_d};
    prod_res_d  = (sa_q ^ sb_q) ? -prod_q : prod_q;
    quo_res_d   = (sa_q ^ sb_q) ? -quo_q : quo_q;
    rem_res_d   = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // Sequencer, datapath registers and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start && !bus.flush) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= bus.op[1];
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= bus.operand_a;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            prod_q   <= {{WIDTH{1'b0}}, mag_b_d};
            rem_q    <= '0;
            quo_q    <= mag_a_d;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (is_div_q) begin
              rem_q <= rem_d;
              quo_q <= quo_d;
            end else begin
              prod_q <= prod_d;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) state_q <= FINISH;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (!is_div_q) begin
              hi_q <= prod_res_d[2*WIDTH-1:WIDTH];
              lo_q <= prod_res_d[WIDTH-1:0];
            end else if (mag_b_q == '0) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_res_d;
              lo_q <= quo_res_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized
// operations against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {hi, lo} from the MIPS rules using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa_l;
    longint sb_l;
    longint q;
    longint r;
    logic [63:0] u;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    u = '0;
    case (op)
      2'd0: u = 64'(sa_l * sb_l);
      2'd1: u = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) u = {a, 32'hFFFF_FFFF};
        else begin
          q = sa_l / sb_l;
          r = sa_l % sb_l;
          u = {32'(r), 32'(q)};
        end
      end
      default: begin
        if (b == 32'd0) u = {a, 32'hFFFF_FFFF};
        else u = {a % b, a / b};
      end
    endcase
    return u;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] special);
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 32'h8000_0000;
    if (s == 1) return 32'hFFFF_FFFF;
    if (s == 2) return special;
    return $urandom;
  endfunction

  // Launch one op and wait (bounded) for done; optionally poke start and
  // MTHI while busy to prove they are ignored.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke,
                        output logic [31:0] hi_o, output logic [31:0] lo_o,
                        output int edges, output int busy_cnt,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    busy_cnt = bus.busy ? 1 : 0;
    edges = 0;
    while (edges < 60 && !bus.done) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cnt++;
      if (poke) begin
        bus.start = (edges == 5);
        bus.hi_we = (edges == 7);
        bus.wdata = $urandom;
        bus.op = 2'($urandom_range(0, 3));
      end
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    hi_o = bus.hi;
    lo_o = bus.lo;
    @(posedge clk);
    #1;
    done_after = bus.done;
    busy_after = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests_run++;
    if (bus.hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    tests_run++;
    if (bus.lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] h, l;
    int e, bc;
    logic da, ba;
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, h, l, e, bc, da, ba);
    tests_run++;
    if (e !== 33) begin tests_failed++; $display("FAIL mult_latency got %0d want 33", e); end
    tests_run++;
    if (bc !== 33) begin tests_failed++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
    tests_run++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
      tests_failed++; $display("FAIL mult_result got %h_%h want ffffffff_ffffffeb", h, l);
    end
    tests_run++;
    if (da !== 1'b0 || ba !== 1'b0) begin
      tests_failed++; $display("FAIL mult_done_pulse done=%b busy=%b want 0/0", da, ba);
    end
  endtask

  task automatic test_multu();
    logic [31:0] h, l;
    int e, bc;
    logic da, ba;
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, h, l, e, bc, da, ba);
    tests_run++;
    if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
      tests_failed++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", h, l);
    end
  endtask

  task automatic test_div();
    logic [31:0] h, l;
    int e, bc;
    logic da, ba;
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, h, l, e, bc, da, ba);
    tests_run++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      tests_failed++; $display("FAIL div_neg7_by_2 got %h_%h want ffffffff_fffffffd", h, l);
    end
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, h, l, e, bc, da, ba);
    tests_run++;
    if (h !== 32'd0 || l !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL div_min_by_m1 got %h_%h want 00000000_80000000", h, l);
    end
  endtask

  task automatic test_divu_zero();
    logic [31:0] h, l;
    int e, bc;
    logic da, ba;
    run_op(2'd3, 32'd100, 32'd0, 1'b0, h, l, e, bc, da, ba);
    tests_run++;
    if (e !== 33) begin tests_failed++; $display("FAIL divu0_latency got %0d want 33", e); end
    tests_run++;
    if (h !== 32'h0000_0064 || l !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL divu0_result got %h_%h want 00000064_ffffffff", h, l);
    end
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, h, l, e, bc, da, ba);
    tests_run++;
    if (h !== 32'hFFFF_FF00 || l !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL div0_signed got %h_%h want ffffff00_ffffffff", h, l);
    end
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    tests_run++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
      tests_failed++; $display("FAIL mthi_mtlo got %h/%h want 1234/5678", bus.hi, bus.lo);
    end
    bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd5; bus.operand_b = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_no_done got %b want 0", seen); end
    tests_run++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
      tests_failed++; $display("FAIL flush_hilo got %h/%h want 1234/5678", bus.hi, bus.lo);
    end
  endtask

  task automatic test_start_flush_idle();
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd0;
    bus.operand_a = 32'd3; bus.operand_b = 32'd3;
    bus.hi_we = 1'b1; bus.wdata = 32'hCAFE;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.hi_we = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL start_flush_busy got %b want 0", bus.busy); end
    tests_run++;
    if (bus.hi !== 32'hCAFE) begin tests_failed++; $display("FAIL flush_idle_mthi got %h want cafe", bus.hi); end
    seen = 1'b0;
    repeat (36) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0 || bus.lo !== 32'h5678) begin
      tests_failed++; $display("FAIL start_flush_launch done_seen=%b lo=%h want 0/5678", seen, bus.lo);
    end
  endtask

  task automatic test_mt_with_start();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd2; bus.operand_b = 32'd2;
    bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    tests_run++;
    if (bus.lo !== 32'hBEEF || bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL mt_start_write lo=%h busy=%b want beef/1", bus.lo, bus.busy);
    end
    n = 0;
    while (n < 60 && !bus.done) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd4) begin
      tests_failed++; $display("FAIL mt_start_overwrite done=%b hi=%h lo=%h want 1/0/4", bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l, a, b;
    logic [1:0] op;
    logic [63:0] exp;
    int e, bc;
    logic da, ba;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick(32'd0);
      b = pick((i % 5 == 0) ? 32'd0 : 32'd1);
      exp = model(op, a, b);
      run_op(op, a, b, (i % 4 == 0), h, l, e, bc, da, ba);
      tests_run++;
      if ({h, l} !== exp || e !== 33 || ba !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_op%0d op=%0d a=%h b=%h got %h_%h lat=%0d busy_after=%b want %h lat=33 busy_after=0",
                 i, op, a, b, h, l, e, ba, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 32'd9; bus.operand_b = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset busy=%b done=%b hi=%h lo=%h want 0/0/0/0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_flush();
    test_start_flush_idle();
    test_mt_with_start();
    test_back_to_back();
    test_multu();
    test_async_reset();
    test_mult();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes operand A from the ID/EX register and operand B from the EX operand-select mux output. It executes MIPS MULT/MULTU/DIV/DIVU over 32 iterations and holds the result in internal HI/LO registers. The hazard unit reads busy/done to stall MFHI/MFLO and any subsequent mult/div.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  EX mux output (multiplier / divisor)
flush  input  1  abort in-flight operation (branch/exception squash)
hi_we  input  1  MTHI write
lo_we  input  1  MTLO write
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse: hi/lo just updated by a mult/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all internal datapath registers=0.
- States:
  - IDLE: on a start edge, go to RUN.
  - RUN: stays for exactly WIDTH edges, then goes to FINISH.
  - FINISH: one edge, then back to IDLE.
- Start edge (E0), capture:
  - op; sign flags, where sa = operand_a[MSB] and sb = operand_b[MSB] for signed ops, and 0 for unsigned ops.
  - Magnitudes |a| and |b|; a signed value of 0x80000000 keeps magnitude 0x80000000 as unsigned.
  - Counter cleared.
- RUN, multiply: shift-add on a 2*WIDTH product register, one multiplier bit per edge, LSB first.
- RUN, divide: restoring division, one quotient bit per edge, MSB first. The remainder register is WIDTH+1 bits to hold the subtract borrow.
- FINISH edge (E33), result adjustment:
  - MULT: {hi,lo} = product, negated if sa^sb.
  - DIV: lo = quotient, negated if sa^sb; hi = remainder, negated if sa.
  - Divide by zero, DIV or DIVU: hi = operand_a as captured (original signed value), lo = all ones. Latency is unchanged.
  - 0x80000000 / -1 (DIV): lo = 0x80000000, hi = 0. This falls out of the magnitude arithmetic naturally.
- Latency:
  - busy=1 from after E0 through E33; it drops and done=1 for the single cycle after E33.
  - Results are visible on hi/lo in that same cycle. Total is 33 edges from start to results.
- Input rules:
  - start while busy is ignored; operands are not resampled.
  - start and flush together in IDLE: flush wins and nothing is launched.
- flush:
  - In RUN or FINISH: return to IDLE on the next edge. busy=0, done is never raised, hi/lo keep their previous values.
  - In IDLE: no effect on hi/lo writes.
- MTHI/MTLO:
  - hi_we/lo_we take effect only in IDLE.
  - start and hi_we/lo_we on the same IDLE edge: the write lands on that edge, and the launched op later overwrites both.
  - hi_we/lo_we while busy are dropped; the hazard unit guarantees this does not occur.
- Asynchronous reset mid-operation aborts immediately and applies the reset values above.
- Counter wrap: the counter is log2(WIDTH)+1 bits and never wraps within an operation.

Test Plan:
- Reset with rst_n=0 mid-RUN, asynchronously between edges -> busy=0, done=0, hi=lo=0 immediately, with no clock edge.
- MULT a=0xFFFFFFFD(-3), b=7 -> done pulse exactly 33 edges after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF after 33 edges.
- Load hi=0x1234, lo=0x5678 via MTHI/MTLO; start MULTU 5*6; assert flush at edge E10 -> busy=0 next cycle, no done pulse, hi/lo remain 0x1234/0x5678. A start asserted while busy produces no second done pulse.
